udp_writer: RTL
===============

Name: udp_writer

Overview:
- Transmit-side counterpart of udp_reader.
- Latches a parallel register of up to CAPACITY bytes and requests a UDP frame from udp_packet.
- Serialises the latched bytes onto the udp_packet TX byte interface (tx_read_en / tx_valid / tx_data / tx_data_len).
- Runs in the rgmii_clk domain. Used for status and reply packets back to the host.

Parameters:
- CAPACITY, 16, payload buffer size in bytes; i_data width is CAPACITY*8.
- TIMEOUT, 1_000_000, cycles to wait for the first tx_read_en after udp_trig before aborting the frame.

Ports:
- clk  input  1  rgmii_clk domain clock.
- rstn  input  1  synchronous active-low reset.
- trig  input  1  send request; rising edge sampled in IDLE.
- i_data  input  CAPACITY*8  payload; byte k = i_data[8k+7:8k]; byte 0 is sent first.
- i_len  input  16  payload length in bytes, legal range 1..CAPACITY.
- udp_trig  output  1  one-cycle pulse to udp_packet.trig.
- tx_read_en  input  1  byte request from udp_packet.
- tx_valid  output  1  byte valid, one cycle after tx_read_en.
- tx_data  output  8  payload byte.
- tx_data_len  output  16  latched frame length, to udp_packet.tx_data_len.
- busy  output  1  high from accepted trig until frame end or abort.
- done  output  1  one-cycle pulse after the last byte is sent.
- err  output  1  one-cycle pulse on bad length or timeout.

Behaviour:
- Reset: all outputs are 0 (udp_trig, tx_valid, tx_data, tx_data_len, busy, done, err). State = IDLE. Byte index = 0. Timeout counter = 0. Shadow buffer is cleared.
- Edge detect: trig is registered; trig_rise = trig & ~trig_d.
- States: IDLE, WAIT, SEND, DONE.
- IDLE, on trig_rise:
  - If 1 <= i_len <= CAPACITY: latch i_data into shadow, latch i_len into tx_data_len, clear index, pulse udp_trig for one cycle, set busy, go to WAIT.
  - Otherwise: pulse err, no udp_trig, stay in IDLE.
- WAIT:
  - Timeout counter increments each cycle.
  - On tx_read_en: go to SEND, handling this cycle exactly as SEND would (counts as byte 0).
  - If the counter reaches TIMEOUT-1 with no tx_read_en: pulse err, clear busy, go to IDLE. udp_trig is not re-issued.
- SEND (each cycle):
  - tx_read_en=1 and index < len: next cycle tx_valid=1 and tx_data=shadow byte[index]; index increments.
  - tx_read_en=0: next cycle tx_valid=0 and tx_data holds its last value; index holds (gaps allowed mid-frame).
  - When the byte with index len-1 is issued, go to DONE.
  - tx_read_en while index >= len (over-read): tx_valid=0, tx_data=0, no error.
- DONE: one cycle; pulse done, clear busy, go to IDLE. tx_data_len keeps the last length until the next accepted trig.
- Latency: tx_read_en to tx_valid/tx_data is exactly 1 cycle. trig rising to udp_trig is 2 cycles (edge register plus state register).
- trig while busy: ignored. The edge is not queued; a new rising edge is required once back in IDLE.
- i_data / i_len changes while busy have no effect on the frame in progress (shadow copy).
- Reset asserted mid-frame: next cycle everything is back at reset values. tx_valid drops immediately and no done is issued.
- Widths: index is $clog2(CAPACITY+1) bits. Length comparison is done at 16 bits, zero-extended.

Test Plan:
- CAPACITY=16, i_data=128'h0F0E..0100, i_len=16, trig pulse, tx_read_en held high after udp_trig:
  - udp_trig 2 cycles after trig.
  - tx_data 00,01,..,0F on 16 consecutive tx_valid cycles, tx_data_len=16.
  - done one cycle after the last valid; busy low afterwards.
- i_len=3, tx_read_en pattern 1,0,0,1,1:
  - tx_valid pattern 1,0,0,1,1, each one cycle after its tx_read_en.
  - Bytes 00,01,02.
  - A further tx_read_en gives tx_valid=0.
- i_len=0, then i_len=17, each with a trig:
  - err pulses once per trig.
  - No udp_trig, busy stays 0.
- TIMEOUT=100, trig accepted, tx_read_en never asserted:
  - err at 100 cycles after entering WAIT; busy falls.
  - A following trig is accepted normally.
- Second trig rising mid-frame, with i_data changed after the first trig:
  - No second udp_trig.
  - Bytes sent match the first latched payload.
- rstn low for 1 cycle after the 5th byte of a 16-byte frame:
  - All outputs 0 next cycle, no done.
  - A new trig restarts at byte 00.

Source files
------------

// File: rtl/udp_writer.sv
// Transmit-side payload serialiser: latches up to CAPACITY bytes on a trig edge,
// requests a UDP frame and feeds the bytes to udp_packet's TX byte interface.
module udp_writer #(
    parameter int CAPACITY = 16,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  trig,
    input  logic [CAPACITY*8-1:0] i_data,
    input  logic [15:0]           i_len,
    output logic                  udp_trig,
    input  logic                  tx_read_en,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic [15:0]           tx_data_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = $clog2(CAPACITY + 1);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      CAP_LEN  = 16'(CAPACITY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  trig_q, trig_qq;
    logic [CAPACITY*8-1:0] shadow_q, shadow_d;
    logic [15:0]           len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  udp_trig_q, udp_trig_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic       trig_rise;
    logic       len_ok;
    logic       serve;
    logic       issue;
    logic [15:0] idx_ext;
    logic [7:0] cur_byte;

    // Two flops on trig: the first is the edge register, so udp_trig lands
    // two edges after trig is first sampled high.
    assign trig_rise = trig_q & ~trig_qq;
    assign len_ok    = (i_len != 16'd0) && (i_len <= CAP_LEN);
    assign idx_ext   = 16'(idx_q);
    assign cur_byte  = 8'(shadow_q >> {idx_q, 3'b000});

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        udp_trig_d = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        serve      = 1'b0;
        issue      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_rise) begin
                    if (len_ok) begin
                        shadow_d   = i_data;
                        len_d      = i_len;
                        idx_d      = '0;
                        cnt_d      = '0;
                        udp_trig_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (tx_read_en) begin
                    // First request is served in this very cycle as byte 0.
                    state_d = S_SEND;
                    serve   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: serve = 1'b1;
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (serve && tx_read_en && (idx_ext < len_q)) begin
            issue      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = cur_byte;
            idx_d      = idx_q + IDX_W'(1);
            if (idx_ext == len_q - 16'd1) begin
                state_d = S_DONE;
            end
        end

        // A request with nothing left to give returns an invalid zero byte.
        if (tx_read_en && !issue) begin
            tx_data_d = 8'h00;
        end
    end

    // NOTE: the shadow buffer is a plain register, so it is cleared with everything else.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            trig_qq    <= 1'b0;
            shadow_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            udp_trig_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            trig_q     <= trig;
            trig_qq    <= trig_q;
            shadow_q   <= shadow_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            udp_trig_q <= udp_trig_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign udp_trig    = udp_trig_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_data_len = len_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
